// File: rtl/trap_arbiter_pkg.sv
// Shared types and constants for the trap arbiter: FSM state encoding, default cause-code
// width and the cause codes of the existing exception sources.
package trap_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StHandler = 2'd2
    } trap_state_e;

    localparam int unsigned CodeWDefault = 4;

    localparam logic [CodeWDefault-1:0] ExcInstrAddrMisaligned = 4'd0;
    localparam logic [CodeWDefault-1:0] ExcInstrAccessFault    = 4'd1;
    localparam logic [CodeWDefault-1:0] ExcIllegalInstr        = 4'd2;
    localparam logic [CodeWDefault-1:0] ExcLoadAccessFault     = 4'd5;
    localparam logic [CodeWDefault-1:0] ExcStoreAccessFault    = 4'd7;

endpackage

// File: rtl/trap_arbiter_if.sv
// Bundle between the exception/interrupt sources plus trap handler (master) and the
// trap arbiter (slave).
interface trap_arbiter_if
    import trap_arbiter_pkg::*;
#(
    parameter int unsigned NExc  = 5,
    parameter int unsigned NIrq  = 4,
    parameter int unsigned Xlen  = 64,
    parameter int unsigned CodeW = CodeWDefault
);
    logic [NExc-1:0]       exc_en;
    logic [NExc*CodeW-1:0] exc_code;
    logic [NExc*Xlen-1:0]  exc_val;
    logic [NIrq-1:0]       irq_lines;
    logic [NIrq-1:0]       irq_mask;
    logic                  global_ie;
    logic                  trap_ack;
    logic                  mret;

    logic                  trap_req;
    logic                  trap_is_irq;
    logic [CodeW-1:0]      trap_code;
    logic [Xlen-1:0]       trap_val;
    logic [NIrq-1:0]       irq_pending;
    logic                  in_handler;
    logic                  double_fault;

    modport master (
        output exc_en, exc_code, exc_val, irq_lines, irq_mask, global_ie, trap_ack, mret,
        input  trap_req, trap_is_irq, trap_code, trap_val, irq_pending, in_handler,
               double_fault
    );

    modport slave (
        input  exc_en, exc_code, exc_val, irq_lines, irq_mask, global_ie, trap_ack, mret,
        output trap_req, trap_is_irq, trap_code, trap_val, irq_pending, in_handler,
               double_fault
    );

endinterface

// File: rtl/trap_arbiter_prio_enc.sv
// First-set priority encoder; MsbFirst selects whether the highest or lowest set bit wins.
module trap_arbiter_prio_enc #(
    parameter int unsigned Width    = 4,
    parameter bit          MsbFirst = 1'b0,
    localparam int unsigned IdxW    = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic             valid_o,
    output logic [IdxW-1:0]  idx_o
);

    // The last match written in each loop is the winner.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        if (MsbFirst) begin
            for (int i = 0; i < int'(Width); i++) begin
                if (req_i[i]) idx_o = IdxW'(i);
            end
        end else begin
            for (int i = int'(Width) - 1; i >= 0; i--) begin
                if (req_i[i]) idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/trap_arbiter.sv
// Registered exception/interrupt arbiter with req/ack handshake and double-fault detection.
// Define TRAP_ARB_IRQ_EDGE_EN to make interrupt lines pend on rising edges only.
module trap_arbiter
    import trap_arbiter_pkg::*;
#(
    parameter int unsigned NExc  = 5,
    parameter int unsigned NIrq  = 4,
    parameter int unsigned Xlen  = 64,
    parameter int unsigned CodeW = CodeWDefault
) (
    input  logic           clk,
    input  logic           rst,
    trap_arbiter_if.slave  bus_io
);

    localparam int unsigned ExcIdxW = (NExc > 1) ? $clog2(NExc) : 1;
    localparam int unsigned IrqIdxW = (NIrq > 1) ? $clog2(NIrq) : 1;

    trap_state_e      state_q, state_d;
    logic [NIrq-1:0]  pend_q, pend_d;
    logic [NIrq-1:0]  irq_sel_q, irq_sel_d;
    logic             is_irq_q, is_irq_d;
    logic [CodeW-1:0] code_q, code_d;
    logic [Xlen-1:0]  val_q, val_d;
    logic             df_q, df_d;

    logic [NIrq-1:0]    irq_set;
    logic [NIrq-1:0]    irq_clr;
    logic [NIrq-1:0]    irq_elig;
    logic               exc_valid, irq_valid;
    logic [ExcIdxW-1:0] exc_idx;
    logic [IrqIdxW-1:0] irq_idx;

`ifdef TRAP_ARB_IRQ_EDGE_EN
    logic [NIrq-1:0] lines_prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lines_prev_q <= '0;
        else      lines_prev_q <= bus_io.irq_lines;
    end

    assign irq_set = bus_io.irq_lines & ~lines_prev_q;
`else
    assign irq_set = bus_io.irq_lines;
`endif

    assign irq_elig = pend_q & bus_io.irq_mask & {NIrq{bus_io.global_ie}};

    trap_arbiter_prio_enc #(
        .Width    (NExc),
        .MsbFirst (1'b0)
    ) u_exc_enc (
        .req_i   (bus_io.exc_en),
        .valid_o (exc_valid),
        .idx_o   (exc_idx)
    );

    trap_arbiter_prio_enc #(
        .Width    (NIrq),
        .MsbFirst (1'b1)
    ) u_irq_enc (
        .req_i   (irq_elig),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    always_comb begin
        state_d   = state_q;
        irq_sel_d = irq_sel_q;
        is_irq_d  = is_irq_q;
        code_d    = code_q;
        val_d     = val_q;
        df_d      = df_q;
        irq_clr   = '0;
        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    is_irq_d  = 1'b0;
                    code_d    = bus_io.exc_code[int'(exc_idx)*CodeW +: CodeW];
                    val_d     = bus_io.exc_val[int'(exc_idx)*Xlen +: Xlen];
                    irq_sel_d = '0;
                    state_d   = StReq;
                end else if (irq_valid) begin
                    is_irq_d  = 1'b1;
                    code_d    = CodeW'(irq_idx);
                    val_d     = '0;
                    irq_sel_d = NIrq'(1) << irq_idx;
                    state_d   = StReq;
                end
            end
            StReq: begin
                // irq_sel_q is all-zero for exceptions, so only a taken irq clears a bit.
                if (bus_io.trap_ack) begin
                    irq_clr = irq_sel_q;
                    state_d = StHandler;
                end
            end
            StHandler: begin
                if (|bus_io.exc_en) df_d = 1'b1;
                if (bus_io.mret)    state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // A new set wins over a clear on the same line.
        pend_d = (pend_q & ~irq_clr) | irq_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            irq_sel_q <= '0;
            is_irq_q  <= 1'b0;
            code_q    <= '0;
            val_q     <= '0;
            df_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            irq_sel_q <= irq_sel_d;
            is_irq_q  <= is_irq_d;
            code_q    <= code_d;
            val_q     <= val_d;
            df_q      <= df_d;
        end
    end

    assign bus_io.trap_req     = (state_q == StReq);
    assign bus_io.in_handler   = (state_q == StHandler);
    assign bus_io.trap_is_irq  = is_irq_q;
    assign bus_io.trap_code    = code_q;
    assign bus_io.trap_val     = val_q;
    assign bus_io.irq_pending  = pend_q;
    assign bus_io.double_fault = df_q;

endmodule
